// File: rtl/present_fifo_wrapper.sv
// PRESENT block-cipher bus front end: key/IV registers, input/output block FIFOs,
// ECB/CBC chaining, driving an external iterative core one block at a time.

module present_fifo_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  // Caller only asserts push/pop when legal; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

module present_fifo_wrapper #(
  parameter int KEY_WIDTH  = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          idat,
  input  logic                 enable_n,
  input  logic                 write_n,
  input  logic                 read_n,
  input  logic [3:0]           address,
  output logic [31:0]          odat,
  output logic                 core_start,
  output logic                 core_decrypt,
  output logic [KEY_WIDTH-1:0] core_key,
  output logic [63:0]          core_din,
  input  logic [63:0]          core_dout,
  input  logic                 core_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;

  logic                 wr, rd, busy, ctrl_wr, clr, clr_flags, key_wr, iv_wr, err_set;
  logic                 din_lo_wr, dout_lo_rd, go, done_acc;
  logic                 in_push, in_pop, out_push, out_pop;
  logic                 in_full, in_empty, out_full, out_empty;
  logic [CW-1:0]        in_count, out_count;
  logic                 dec, cbc, ovf, udf, err, discard;
  logic [KEY_WIDTH-1:0] key_r;
  logic [31:0]          iv_hi, iv_lo, din_hi, rdata, status;
  logic [63:0]          chain, result, in_head, out_head;

  assign wr         = !enable_n && !write_n;
  assign rd         = !enable_n && !read_n && write_n;
  assign busy       = (state != IDLE);
  assign ctrl_wr    = wr && (address == 4'd0);
  assign clr        = ctrl_wr && idat[2];
  assign clr_flags  = clr || (ctrl_wr && idat[3]);
  assign key_wr     = wr && ((address inside {4'd2, 4'd3, 4'd4}) ||
                             (address == 4'd5 && KEY_WIDTH == 128));
  assign iv_wr      = wr && (address == 4'd6 || address == 4'd7);
  assign din_lo_wr  = wr && (address == 4'd9);
  assign dout_lo_rd = rd && (address == 4'd11);
  // A clear/clr_err write while busy is legitimate; only mode/key/IV changes flag err.
  assign err_set    = busy && ((ctrl_wr && !clr_flags) || key_wr || iv_wr);

  // Holding off issue on a clear edge keeps the flush from racing the engine pop.
  assign go       = (state == IDLE) && !in_empty && !out_full && !clr;
  assign done_acc = (state == WAIT) && core_done;
  assign in_pop   = go;
  assign in_push  = din_lo_wr && (!in_full || in_pop);
  assign out_push = done_acc && !discard && !clr;
  assign out_pop  = dout_lo_rd && !out_empty;
  assign result   = (cbc && dec) ? (core_dout ^ chain) : core_dout;

  present_fifo_buf #(.W(64), .DEPTH(FIFO_DEPTH), .CW(CW)) u_in (
    .clk, .reset, .flush(clr), .push(in_push), .pop(in_pop), .wdata({din_hi, idat}),
    .head(in_head), .full(in_full), .empty(in_empty), .count(in_count));

  present_fifo_buf #(.W(64), .DEPTH(FIFO_DEPTH), .CW(CW)) u_out (
    .clk, .reset, .flush(clr), .push(out_push), .pop(out_pop), .wdata(result),
    .head(out_head), .full(out_full), .empty(out_empty), .count(out_count));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    case (state)
      IDLE:  if (go) state_nx = ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT:  if (core_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec      <= 1'b0;
      cbc      <= 1'b0;
      key_r    <= '0;
      iv_hi    <= '0;
      iv_lo    <= '0;
      din_hi   <= '0;
      chain    <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      err      <= 1'b0;
      discard  <= 1'b0;
      core_din <= '0;
      odat     <= '0;
    end else begin
      if (ctrl_wr && !busy) begin
        dec <= idat[0];
        cbc <= idat[1];
      end
      if (key_wr && !busy) begin
        case (address)
          4'd2: key_r[KEY_WIDTH-1 -: 32]  <= idat;
          4'd3: key_r[KEY_WIDTH-33 -: 32] <= idat;
          4'd4: if (KEY_WIDTH == 128) key_r[63:32] <= idat;
                else                  key_r[15:0]  <= idat[15:0];
          default: if (KEY_WIDTH == 128) key_r[31:0] <= idat;
        endcase
      end
      if (wr && address == 4'd6 && !busy) iv_hi <= idat;
      if (wr && address == 4'd7 && !busy) iv_lo <= idat;
      if (wr && address == 4'd8)          din_hi <= idat;

      // In decrypt mode core_din is the raw ciphertext block, so it doubles as blk.
      if (clr)                                  chain <= {iv_hi, iv_lo};
      else if (wr && address == 4'd7 && !busy)  chain <= {iv_hi, idat};
      else if (out_push && cbc)                 chain <= dec ? core_din : core_dout;

      if (go) core_din <= (cbc && !dec) ? (in_head ^ chain) : in_head;

      if (done_acc)         discard <= 1'b0;
      else if (clr && busy) discard <= 1'b1;

      ovf <= clr_flags ? 1'b0 : (ovf | (din_lo_wr && in_full && !in_pop));
      udf <= clr_flags ? 1'b0 : (udf | (dout_lo_rd && out_empty));
      err <= clr_flags ? 1'b0 : (err | err_set);

      if (rd) odat <= rdata;
    end
  end

  assign status = {8'b0, 8'(out_count), 8'(in_count),
                   err, udf, ovf, out_empty, out_full, in_empty, in_full, busy};

  always_comb begin
    rdata = '0;
    case (address)
      4'd0:  rdata = {30'b0, cbc, dec};
      4'd1:  rdata = status;
      4'd2:  rdata = key_r[KEY_WIDTH-1 -: 32];
      4'd3:  rdata = key_r[KEY_WIDTH-33 -: 32];
      4'd4:  rdata = (KEY_WIDTH == 128) ? key_r[63:32] : {16'b0, key_r[15:0]};
      4'd5:  rdata = (KEY_WIDTH == 128) ? key_r[31:0] : 32'b0;
      4'd6:  rdata = iv_hi;
      4'd7:  rdata = iv_lo;
      4'd8:  rdata = din_hi;
      4'd10: if (!out_empty) rdata = out_head[63:32];
      4'd11: if (!out_empty) rdata = out_head[31:0];
      default: ;
    endcase
  end

  assign core_decrypt = dec;
  assign core_key     = key_r;
endmodule

// File: tb/tb_present_fifo_wrapper.sv
// Scoreboard bench for present_fifo_wrapper: 80-bit and 128-bit instances, each
// served by a behavioural PRESENT core with adjustable latency and a hold-off input.

module tb_present_fifo_wrapper;
  logic         clk = 1'b0, reset = 1'b1;
  logic [31:0]  idat = '0;
  logic         en80_n = 1'b1, en128_n = 1'b1, write_n = 1'b1, read_n = 1'b1;
  logic [3:0]   address = '0;
  logic [31:0]  odat80, odat128;
  logic         start80, dec80, start128, dec128;
  logic [79:0]  key80;
  logic [127:0] key128;
  logic [63:0]  din80, din128;
  logic [63:0]  dout80 = '0, dout128 = '0;
  logic         done80 = 1'b0, done128 = 1'b0;

  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  present_fifo_wrapper #(.KEY_WIDTH(80), .FIFO_DEPTH(4)) u80 (
    .clk(clk), .reset(reset), .idat(idat), .enable_n(en80_n), .write_n(write_n),
    .read_n(read_n), .address(address), .odat(odat80), .core_start(start80),
    .core_decrypt(dec80), .core_key(key80), .core_din(din80), .core_dout(dout80),
    .core_done(done80));

  present_fifo_wrapper #(.KEY_WIDTH(128), .FIFO_DEPTH(4)) u128 (
    .clk(clk), .reset(reset), .idat(idat), .enable_n(en128_n), .write_n(write_n),
    .read_n(read_n), .address(address), .odat(odat128), .core_start(start128),
    .core_decrypt(dec128), .core_key(key128), .core_din(din128), .core_dout(dout128),
    .core_done(done128));

  // ---------------- PRESENT reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    int i;
    t = 64'hC56B90AD3EF84712;
    i = int'(x);
    return t[63-4*i -: 4];
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int y = 0; y < 16; y++) if (sb(4'(y)) == x) r = 4'(y);
    return r;
  endfunction

  function automatic int pl(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [63:0] present(input logic [127:0] key, input bit k128,
                                          input bit dec, input logic [63:0] din);
    logic [63:0]  rk [32];
    logic [127:0] k;
    logic [63:0]  s, t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r-1] = k128 ? k[127:64] : k[79:16];
      if (k128) begin
        k = {k[66:0], k[127:67]};
        k[127:124] = sb(k[127:124]);
        k[123:120] = sb(k[123:120]);
        k[66:62]   = k[66:62] ^ 5'(r);
      end else begin
        k[79:0]  = {k[18:0], k[79:19]};
        k[79:76] = sb(k[79:76]);
        k[19:15] = k[19:15] ^ 5'(r);
      end
    end
    if (!dec) begin
      s = din;
      for (int r = 0; r < 31; r++) begin
        s = s ^ rk[r];
        for (int j = 0; j < 16; j++) s[4*j +: 4] = sb(s[4*j +: 4]);
        t = '0;
        for (int i = 0; i < 64; i++) t[pl(i)] = s[i];
        s = t;
      end
      s = s ^ rk[31];
    end else begin
      s = din ^ rk[31];
      for (int r = 30; r >= 0; r--) begin
        for (int i = 0; i < 64; i++) t[i] = s[pl(i)];
        s = t;
        for (int j = 0; j < 16; j++) s[4*j +: 4] = isb(s[4*j +: 4]);
        s = s ^ rk[r];
      end
    end
    return s;
  endfunction

  // ---------------- core models ----------------
  bit          hold80 = 1'b0, pend80 = 1'b0, pend128 = 1'b0;
  int          cnt80 = 0, cnt128 = 0;
  logic [63:0] res80 = '0, res128 = '0;

  always @(posedge clk) begin
    done80 <= 1'b0;
    if (reset) pend80 <= 1'b0;
    else if (start80) begin
      pend80 <= 1'b1;
      cnt80  <= 3;
      res80  <= present({48'b0, key80}, 1'b0, dec80, din80);
    end else if (pend80 && !hold80) begin
      if (cnt80 == 0) begin
        done80 <= 1'b1;
        dout80 <= res80;
        pend80 <= 1'b0;
      end else cnt80 <= cnt80 - 1;
    end
  end

  always @(posedge clk) begin
    done128 <= 1'b0;
    if (reset) pend128 <= 1'b0;
    else if (start128) begin
      pend128 <= 1'b1;
      cnt128  <= 2;
      res128  <= present(key128, 1'b1, dec128, din128);
    end else if (pend128) begin
      if (cnt128 == 0) begin
        done128 <= 1'b1;
        dout128 <= res128;
        pend128 <= 1'b0;
      end else cnt128 <= cnt128 - 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic bus_wr(input bit sel, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; idat = d; write_n = 1'b0; read_n = 1'b1;
    en80_n = sel; en128_n = !sel;
    @(negedge clk);
    write_n = 1'b1; en80_n = 1'b1; en128_n = 1'b1;
  endtask

  task automatic bus_rd(input bit sel, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read_n = 1'b0; write_n = 1'b1;
    en80_n = sel; en128_n = !sel;
    @(negedge clk);
    d = sel ? odat128 : odat80;
    read_n = 1'b1; en80_n = 1'b1; en128_n = 1'b1;
  endtask

  task automatic push_blk(input bit sel, input logic [63:0] b);
    bus_wr(sel, 4'd8, b[63:32]);
    bus_wr(sel, 4'd9, b[31:0]);
  endtask

  task automatic wait_cnt(input bit sel, input int n);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      bus_rd(sel, 4'd1, s);
      ok = (int'(s[23:16]) == n);
    end
    if (!ok) check("wait_out_count", 64'(s[23:16]), 64'(n));
  endtask

  task automatic wait_idle(input bit sel);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      bus_rd(sel, 4'd1, s);
      ok = !s[0];
    end
    if (!ok) check("wait_idle", 64'(s[0]), 64'd0);
  endtask

  task automatic pop_result(input bit sel);
    logic [31:0] hi, lo;
    logic [63:0] e;
    bus_rd(sel, 4'd10, hi);
    bus_rd(sel, 4'd11, lo);
    if (exp_q.size() == 0) check("sb_underrun", 64'd0, 64'd1);
    else begin
      e = exp_q.pop_front();
      check("dout_hi", 64'(hi), 64'(e[63:32]));
      check("dout_lo", 64'(lo), 64'(e[31:0]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] s;
    logic [63:0] c1, c2;

    repeat (2) @(negedge clk);
    check("rst_odat", 64'(odat80), 64'd0);
    check("rst_start", 64'(start80), 64'd0);
    check("rst_key", 64'(key80[63:0]) | 64'(key80[79:64]), 64'd0);
    check("rst_din", din80, 64'd0);
    check("rst_dec", 64'(dec80), 64'd0);
    reset = 1'b0;
    bus_rd(1'b0, 4'd1, s);
    check("rst_status", 64'(s), 64'h14);

    // ECB encrypt, key 0; issue timing relative to the DIN_LO edge
    push_blk(1'b0, 64'h0);
    exp_q.push_back(64'h5579c1387b228445);
    check("start_edge_n", 64'(start80), 64'd0);
    @(negedge clk);
    check("start_edge_n1", 64'(start80), 64'd1);
    @(negedge clk);
    check("start_edge_n2", 64'(start80), 64'd0);
    wait_cnt(1'b0, 1);
    pop_result(1'b0);
    bus_rd(1'b0, 4'd1, s);
    check("status_after_pop", 64'(s), 64'h14);

    // all-ones 80-bit key, encrypt then decrypt
    bus_wr(1'b0, 4'd2, 32'hffffffff);
    bus_wr(1'b0, 4'd3, 32'hffffffff);
    bus_wr(1'b0, 4'd4, 32'hffffffff);
    check("key80_ones", 64'(key80[63:0]) & 64'(key80[79:64]), 64'hffff);
    check("key80_lo", key80[63:0], 64'hffffffffffffffff);
    push_blk(1'b0, 64'h0);
    exp_q.push_back(64'he72c46c0f5945049);
    wait_cnt(1'b0, 1);
    pop_result(1'b0);
    bus_wr(1'b0, 4'd0, 32'h1);
    check("dec_out", 64'(dec80), 64'd1);
    push_blk(1'b0, 64'he72c46c0f5945049);
    exp_q.push_back(64'h0);
    wait_cnt(1'b0, 1);
    pop_result(1'b0);

    // 128-bit key instance
    push_blk(1'b1, 64'h0);
    exp_q.push_back(64'h96db702a2e6900af);
    wait_cnt(1'b1, 1);
    pop_result(1'b1);

    // CBC encrypt two zero blocks, IV 0, key 0
    for (int a = 2; a <= 4; a++) bus_wr(1'b0, 4'(a), 32'h0);
    bus_wr(1'b0, 4'd0, 32'h2);
    bus_wr(1'b0, 4'd6, 32'h0);
    bus_wr(1'b0, 4'd7, 32'h0);
    c1 = 64'h5579c1387b228445;
    c2 = present(128'h0, 1'b0, 1'b0, c1);
    push_blk(1'b0, 64'h0);
    exp_q.push_back(c1);
    push_blk(1'b0, 64'h0);
    exp_q.push_back(c2);
    wait_cnt(1'b0, 2);
    pop_result(1'b0);
    pop_result(1'b0);

    // CBC decrypt back to zeros
    bus_wr(1'b0, 4'd0, 32'h3);
    bus_wr(1'b0, 4'd7, 32'h0);
    push_blk(1'b0, c1);
    exp_q.push_back(64'h0);
    push_blk(1'b0, c2);
    exp_q.push_back(64'h0);
    wait_cnt(1'b0, 2);
    pop_result(1'b0);
    pop_result(1'b0);

    // overflow / underflow / err / clear with the core held off
    bus_wr(1'b0, 4'd0, 32'h0);
    hold80 = 1'b1;
    for (int i = 0; i < 6; i++) push_blk(1'b0, 64'h1000 + 64'(i));
    bus_rd(1'b0, 4'd1, s);
    check("ovf_status", 64'(s), 64'h433);
    bus_rd(1'b0, 4'd11, s);
    check("udf_odat", 64'(s), 64'd0);
    bus_rd(1'b0, 4'd1, s);
    check("udf_status", 64'(s), 64'h473);
    bus_wr(1'b0, 4'd0, 32'h1);
    check("busy_dec_held", 64'(dec80), 64'd0);
    bus_rd(1'b0, 4'd1, s);
    check("err_status", 64'(s), 64'h4f3);
    bus_wr(1'b0, 4'd0, 32'h4);
    bus_rd(1'b0, 4'd1, s);
    check("clear_busy_status", 64'(s), 64'h15);
    hold80 = 1'b0;
    wait_idle(1'b0);
    bus_rd(1'b0, 4'd1, s);
    check("clear_discard_status", 64'(s), 64'h14);

    // async reset in the middle of a transaction
    bus_wr(1'b0, 4'd2, 32'h12345678);
    bus_wr(1'b0, 4'd0, 32'h1);
    bus_wr(1'b0, 4'd6, 32'hdeadbeef);
    bus_rd(1'b0, 4'd6, s);
    check("iv_hi_readback", 64'(s), 64'hdeadbeef);
    hold80 = 1'b1;
    push_blk(1'b0, 64'h0123456789abcdef);
    repeat (3) @(negedge clk);
    check("wait_din", din80, 64'h0123456789abcdef);
    #2 reset = 1'b1;
    #1;
    check("arst_odat", 64'(odat80), 64'd0);
    check("arst_start", 64'(start80), 64'd0);
    check("arst_dec", 64'(dec80), 64'd0);
    check("arst_key", key80[63:0], 64'd0);
    check("arst_din", din80, 64'd0);
    hold80 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_rd(1'b0, 4'd1, s);
    check("arst_status", 64'(s), 64'h14);

    if (exp_q.size() != 0) check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
